// File: rtl/sbox_generator_pkg.sv
// ---------------------------------------------------------------------------
// sbox_generator_pkg
// Shared definitions for the chaotic S-box generator and its key_generator
// consumer: default geometry constants and the generator FSM encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package sbox_generator_pkg;

  // Default geometry: 8-bit entries (256-entry table), Q0.32 chaotic state,
  // and 64 consecutive rejections before falling back to linear probing.
  localparam int DEF_V_SIZE    = 8;
  localparam int DEF_SEED_W    = 32;
  localparam int DEF_MAX_TRIES = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    PROBE = 2'd2,
    DONE  = 2'd3
  } sboxState_e;

endpackage

// File: rtl/sbox_generator_logistic_map_q.sv
// ---------------------------------------------------------------------------
// logistic_map_q
// Purely combinational fixed-point logistic map, x' = 4*x*(1-x), with x in
// Q0.SEED_W. Computed as (x * (2^SEED_W - x)) >> (SEED_W-2); the single
// value that reaches 1.0 (x = 0.5) saturates to all-ones.
//
// Ports
//   x_i       [SEED_W-1:0]  current chaotic state
//   x_next_o  [SEED_W-1:0]  next chaotic state
// ---------------------------------------------------------------------------
module logistic_map_q
  import sbox_generator_pkg::*;
#(
  parameter int SEED_W = DEF_SEED_W
) (
  input  logic [SEED_W-1:0] x_i,
  output logic [SEED_W-1:0] x_next_o
);

  localparam int PW = 2 * SEED_W + 1;

  // (1 - x) needs one extra bit because x = 0 gives exactly 2^SEED_W.
  logic [SEED_W:0] oneMinusX;
  logic [PW-1:0]   opA;
  logic [PW-1:0]   opB;
  logic [PW-1:0]   product;
  logic [PW-1:0]   shifted;
  logic            overflow;

  assign oneMinusX = {1'b1, {SEED_W{1'b0}}} - {1'b0, x_i};
  assign opA       = PW'(x_i);
  assign opB       = PW'(oneMinusX);
  assign product   = opA * opB;
  assign shifted   = product >> (SEED_W - 2);

  // Anything at or above 2^SEED_W no longer fits Q0.SEED_W.
  assign overflow  = |shifted[PW-1:SEED_W];
  assign x_next_o  = overflow ? {SEED_W{1'b1}} : shifted[SEED_W-1:0];

endmodule

// File: rtl/sbox_generator.sv
// ---------------------------------------------------------------------------
// sbox_generator
// Produces a bijective V_SIZE-bit S-box, one entry per sbox_valid pulse.
// Candidates come from the top bits of an iterated logistic map; a bitmap of
// already-emitted values rejects repeats. After MAX_TRIES consecutive
// rejections a linear probe from cand+1 finds the next free value, which
// guarantees forward progress.
//
// Ports
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   start       one-cycle request for a new table (only honoured in IDLE)
//   seed        initial chaotic state, sampled with start (0 is loaded as 1)
//   sbox_valid  V_out carries a new entry this cycle
//   V_out       S-box entry; holds its last value when sbox_valid is low
//   sbox_done   one-cycle pulse the cycle after the final entry
//   busy        FSM is not in IDLE
// ---------------------------------------------------------------------------
module sbox_generator
  import sbox_generator_pkg::*;
#(
  parameter int V_SIZE    = DEF_V_SIZE,
  parameter int SEED_W    = DEF_SEED_W,
  parameter int MAX_TRIES = DEF_MAX_TRIES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [SEED_W-1:0] seed,
  output logic              sbox_valid,
  output logic [V_SIZE-1:0] V_out,
  output logic              sbox_done,
  output logic              busy
);

  localparam int                 N        = 1 << V_SIZE;
  localparam int                 TRIES_W  = $clog2(MAX_TRIES + 1);
  localparam logic [V_SIZE:0]    TOTAL    = {1'b1, {V_SIZE{1'b0}}};
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);
  localparam logic [SEED_W-1:0]  SEED_ONE = {{(SEED_W-1){1'b0}}, 1'b1};

  sboxState_e          state_q, state_d;
  logic [SEED_W-1:0]   x_q, x_d, xNext;
  logic [N-1:0]        used_q, used_d;
  logic [V_SIZE:0]     count_q, count_d;
  logic [TRIES_W-1:0]  tries_q, tries_d;
  logic [V_SIZE-1:0]   probe_q, probe_d;
  logic                valid_q, valid_d;
  logic [V_SIZE-1:0]   vOut_q, vOut_d;

  logic [V_SIZE-1:0]   cand;
  logic                candUsed;
  logic                probeUsed;
  logic                runComplete;
  logic                emit;
  logic [V_SIZE-1:0]   emitVal;

  logistic_map_q #(
    .SEED_W (SEED_W)
  ) uMap (
    .x_i      (x_q),
    .x_next_o (xNext)
  );

  assign cand        = xNext[SEED_W-1 -: V_SIZE];
  assign candUsed    = used_q[cand];
  assign probeUsed   = used_q[probe_q];
  assign runComplete = (count_q == TOTAL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Once every value has been emitted, ITER stops looking at candidates and
  // only steps to DONE, so sbox_done lands one cycle after the last valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ITER;
      ITER: begin
        if (runComplete) begin
          state_d = DONE;
        end else if (candUsed && (tries_q == LAST_TRY)) begin
          state_d = PROBE;
        end
      end
      PROBE:   if (!probeUsed) state_d = ITER;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state. Both ITER and PROBE funnel accepted values through
  // one emit path so bitmap, counters and the registered output stay in step.
  always_comb begin
    x_d     = x_q;
    used_d  = used_q;
    count_d = count_q;
    tries_d = tries_q;
    probe_d = probe_q;
    valid_d = 1'b0;
    vOut_d  = vOut_q;
    emit    = 1'b0;
    emitVal = cand;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = (seed == '0) ? SEED_ONE : seed;
          used_d  = '0;
          count_d = '0;
          tries_d = '0;
        end
      end
      ITER: begin
        if (!runComplete) begin
          x_d = xNext;
          if (!candUsed) begin
            emit    = 1'b1;
            emitVal = cand;
          end else if (tries_q != LAST_TRY) begin
            tries_d = tries_q + 1'b1;
          end else begin
            probe_d = cand + 1'b1;
          end
        end
      end
      PROBE: begin
        if (!probeUsed) begin
          emit    = 1'b1;
          emitVal = probe_q;
        end else begin
          probe_d = probe_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (emit) begin
      valid_d         = 1'b1;
      vOut_d          = emitVal;
      used_d[emitVal] = 1'b1;
      tries_d         = '0;
      count_d         = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      used_q  <= '0;
      count_q <= '0;
      tries_q <= '0;
      probe_q <= '0;
      valid_q <= 1'b0;
      vOut_q  <= '0;
    end else begin
      x_q     <= x_d;
      used_q  <= used_d;
      count_q <= count_d;
      tries_q <= tries_d;
      probe_q <= probe_d;
      valid_q <= valid_d;
      vOut_q  <= vOut_d;
    end
  end

  assign sbox_valid = valid_q;
  assign V_out      = vOut_q;
  assign sbox_done  = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_generator.sv
// ---------------------------------------------------------------------------
// tb_sbox_generator
// Self-checking bench for sbox_generator with default parameters. A reference
// model of the generation algorithm fills a scoreboard queue before each run;
// every sbox_valid pops and compares one entry.
// ---------------------------------------------------------------------------
module tb_sbox_generator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] seed;
  logic        sboxValid;
  logic [7:0]  vOut;
  logic        sboxDone;
  logic        busy;

  int nChecks = 0;
  int nFail   = 0;

  logic [7:0] expQ[$];

  typedef struct {
    logic [31:0] seed;
    logic [31:0] modelSeed;
    int          abortAfter;
    bit          pokeStart;
    int          expValid;
    int          expDone;
  } runVec_t;

  runVec_t runs[5];

  sbox_generator dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .seed       (seed),
    .sbox_valid (sboxValid),
    .V_out      (vOut),
    .sbox_done  (sboxDone),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference algorithm: logistic map candidates, bitmap rejection, linear
  // probe from cand+1 after 64 consecutive rejections.
  task automatic loadModel(input logic [31:0] s);
    logic [31:0] x;
    logic [63:0] prod;
    logic [63:0] nx;
    logic [7:0]  cand;
    logic [7:0]  p;
    bit          used[256];
    int          count;
    int          tries;
    foreach (used[i]) used[i] = 1'b0;
    x     = (s == 32'd0) ? 32'd1 : s;
    count = 0;
    tries = 0;
    expQ.delete();
    while (count < 256) begin
      prod = {32'd0, x} * (64'h1_0000_0000 - {32'd0, x});
      nx   = prod >> 30;
      x    = (nx > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : nx[31:0];
      cand = x[31:24];
      if (!used[cand]) begin
        expQ.push_back(cand);
        used[cand] = 1'b1;
        tries = 0;
        count++;
      end else if (tries < 63) begin
        tries++;
      end else begin
        p = cand + 8'd1;
        while (used[p]) p = p + 8'd1;
        expQ.push_back(p);
        used[p] = 1'b1;
        tries = 0;
        count++;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed  = 32'hA5A5_0F0F;
    checkOutput("validTooEarly", 32'(sboxValid), 32'd0);
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
  endtask

  // Samples on falling edges until the run ends (done, abort or timeout).
  task automatic runCapture(input int abortAfter, input bit pokeStart,
                            input int maxCycles, output int nValid,
                            output int nDone);
    int         cyc;
    int         lastValidCyc;
    bit         seen[256];
    bit         poked;
    bit         pokeClear;
    bit         doneSeen;
    bit         running;
    logic [7:0] lastVal;
    logic [7:0] e;
    foreach (seen[i]) seen[i] = 1'b0;
    cyc = 0; lastValidCyc = -10; poked = 0; pokeClear = 0;
    doneSeen = 0; running = 1; lastVal = 8'd0;
    nValid = 0; nDone = 0;
    while (running) begin
      @(negedge clk);
      cyc++;
      if (pokeClear) begin
        start     = 1'b0;
        pokeClear = 1'b0;
      end
      if (doneSeen) begin
        checkOutput("busyAfterDone", 32'(busy), 32'd0);
        checkOutput("validAfterDone", 32'(sboxValid), 32'd0);
        checkOutput("vOutHeld", 32'(vOut), 32'(lastVal));
        running = 0;
      end else begin
        if (sboxValid) begin
          nValid++;
          lastValidCyc = cyc;
          if (expQ.size() == 0) begin
            checkOutput("unexpectedValid", 32'd1, 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("vOut", 32'(vOut), 32'(e));
          end
          checkOutput("distinct", 32'(seen[vOut]), 32'd0);
          seen[vOut] = 1'b1;
          lastVal    = vOut;
        end
        if (sboxDone) begin
          nDone++;
          checkOutput("doneAfterLastValid", 32'(cyc - lastValidCyc), 32'd1);
          doneSeen = 1;
        end
        if (pokeStart && !poked && nValid == 50) begin
          seed      = 32'hDEAD_BEEF;
          start     = 1'b1;
          poked     = 1;
          pokeClear = 1;
        end
        if (abortAfter > 0 && nValid == abortAfter) begin
          reset_n = 1'b0;
          #1;
          checkOutput("abortValid", 32'(sboxValid), 32'd0);
          checkOutput("abortVOut", 32'(vOut), 32'd0);
          checkOutput("abortDone", 32'(sboxDone), 32'd0);
          checkOutput("abortBusy", 32'(busy), 32'd0);
          expQ.delete();
          @(negedge clk);
          reset_n = 1'b1;
          repeat (3) begin
            @(negedge clk);
            if (sboxDone) nDone++;
            checkOutput("idleAfterAbort", 32'(busy), 32'd0);
          end
          running = 0;
        end else if (cyc >= maxCycles) begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL timeout: waited %0d cycles, run still active", cyc);
          running = 0;
        end
      end
    end
  endtask

  initial begin
    int         nValid;
    int         nDone;
    logic [7:0] v;

    reset_n = 1'b0;
    start   = 1'b0;
    seed    = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("resetValid", 32'(sboxValid), 32'd0);
    checkOutput("resetVOut", 32'(vOut), 32'd0);
    checkOutput("resetDone", 32'(sboxDone), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idleBusy", 32'(busy), 32'd0);

    runs[0] = '{seed: 32'h1234_5678, modelSeed: 32'h1234_5678, abortAfter: 0,
                pokeStart: 0, expValid: 256, expDone: 1};
    runs[1] = '{seed: 32'h1234_5678, modelSeed: 32'h1234_5678, abortAfter: 100,
                pokeStart: 0, expValid: 100, expDone: 0};
    runs[2] = '{seed: 32'h1234_5678, modelSeed: 32'h1234_5678, abortAfter: 0,
                pokeStart: 0, expValid: 256, expDone: 1};
    runs[3] = '{seed: 32'h1234_5678, modelSeed: 32'h1234_5678, abortAfter: 0,
                pokeStart: 1, expValid: 256, expDone: 1};
    runs[4] = '{seed: 32'h0000_0000, modelSeed: 32'h0000_0001, abortAfter: 0,
                pokeStart: 0, expValid: 256, expDone: 1};

    for (int r = 0; r < 5; r++) begin
      $display("[TB] run %0d seed=%08h", r, runs[r].seed);
      loadModel(runs[r].modelSeed);
      applyStimulus(runs[r].seed);
      runCapture(runs[r].abortAfter, runs[r].pokeStart, 40000, nValid, nDone);
      checkOutput("validCount", 32'(nValid), 32'(runs[r].expValid));
      checkOutput("doneCount", 32'(nDone), 32'(runs[r].expDone));
      checkOutput("leftoverExpected", 32'(expQ.size()), 32'd0);
    end

    // Seed 0.75 is a fixed point of the map: every emission after the first
    // comes from the probe, so the order walks upward from C0 and wraps.
    $display("[TB] fixed-point seed C0000000");
    expQ.delete();
    for (int i = 0; i < 66; i++) begin
      v = 8'hC0 + 8'(i);
      expQ.push_back(v);
    end
    applyStimulus(32'hC000_0000);
    runCapture(66, 1'b0, 20000, nValid, nDone);
    checkOutput("fixedValidCount", 32'(nValid), 32'd66);
    checkOutput("fixedDoneCount", 32'(nDone), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
